// File: rtl/eth_rx_frame_filter.sv
// Receive frame filter: dest-MAC / FCS / length checks on the rx byte stream,
// writing accepted frames into a ring of receive slots and committing lengths.
module eth_rx_frame_filter #(
   parameter int NBUF_LOG2 = 3,
   parameter int BUF_AW    = 11,
   parameter int MIN_LEN   = 60
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [47:0]               mac_address,
   input  logic                      promiscuous,
   input  logic [7:0]                rx_axis_tdata,
   input  logic                      rx_axis_tvalid,
   input  logic                      rx_axis_tlast,
   input  logic                      rx_axis_tuser,
   input  logic [NBUF_LOG2:0]        firstbuf,
   output logic                      wr_en,
   output logic [NBUF_LOG2+BUF_AW-1:0] wr_addr,
   output logic [7:0]                wr_data,
   output logic                      len_wr_en,
   output logic [NBUF_LOG2-1:0]      len_wr_idx,
   output logic [BUF_AW-1:0]         len_wr_data,
   output logic [NBUF_LOG2:0]        nextbuf,
   output logic                      full,
   output logic [15:0]               cnt_filtered,
   output logic [15:0]               cnt_overrun,
   output logic [15:0]               cnt_bad
);

   localparam int PW = NBUF_LOG2 + 1;
   localparam int AW = NBUF_LOG2 + BUF_AW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_BODY,
      S_DROP
   } state_t;

   state_t            state_q, state_d;
   logic [BUF_AW-1:0] byte_cnt_q, byte_cnt_d;
   logic [39:0]       dest_q, dest_d;
   logic              ovs_q, ovs_d;
   logic              drop_ovr_q, drop_ovr_d;
   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              len_wr_en_q, len_wr_en_d;
   logic [NBUF_LOG2-1:0] len_idx_q, len_idx_d;
   logic [BUF_AW-1:0] len_data_q, len_data_d;
   logic [PW-1:0]     nextbuf_q, nextbuf_d;
   logic [15:0]       cnt_filt_q, cnt_filt_d;
   logic [15:0]       cnt_ovr_q, cnt_ovr_d;
   logic [15:0]       cnt_bad_q, cnt_bad_d;

   logic              full_c;
   logic [47:0]       dest_shift;
   logic              match;
   logic              cnt_max;
   logic [BUF_AW:0]   frame_len;
   logic              inc_bad, inc_filt, inc_ovr;
   logic              body_bad;

   // Ring full when producer is exactly one lap ahead of the consumer.
   assign full_c = (nextbuf_q == {~firstbuf[NBUF_LOG2],
                                  firstbuf[NBUF_LOG2-1:0]});

   assign dest_shift = {dest_q, rx_axis_tdata};
   assign match = promiscuous
                | (dest_shift[47:24] == 24'h01005E)
                | (dest_shift == 48'hFFFF_FFFF_FFFF)
                | (dest_shift == mac_address);

   assign cnt_max   = (byte_cnt_q == '1);
   assign frame_len = {1'b0, byte_cnt_q} + (BUF_AW+1)'(1);
   assign body_bad  = rx_axis_tuser | ovs_q | cnt_max
                    | (frame_len < (BUF_AW+1)'(MIN_LEN));

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      dest_d      = dest_q;
      ovs_d       = ovs_q;
      drop_ovr_d  = drop_ovr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      len_wr_en_d = 1'b0;
      len_idx_d   = len_idx_q;
      len_data_d  = len_data_q;
      nextbuf_d   = nextbuf_q;
      inc_bad     = 1'b0;
      inc_filt    = 1'b0;
      inc_ovr     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            byte_cnt_d = '0;
            if (rx_axis_tvalid) begin
               if (full_c) begin
                  drop_ovr_d = 1'b1;
                  if (rx_axis_tlast) inc_ovr = 1'b1;
                  else               state_d = S_DROP;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {nextbuf_q[NBUF_LOG2-1:0], byte_cnt_q};
                  wr_data_d = rx_axis_tdata;
                  dest_d    = dest_shift[39:0];
                  ovs_d     = 1'b0;
                  if (rx_axis_tlast) begin
                     inc_bad = 1'b1;
                  end else begin
                     byte_cnt_d = BUF_AW'(1);
                     state_d    = S_HDR;
                  end
               end
            end
         end
         S_HDR: begin
            if (rx_axis_tvalid) begin
               wr_en_d    = 1'b1;
               wr_addr_d  = {nextbuf_q[NBUF_LOG2-1:0], byte_cnt_q};
               wr_data_d  = rx_axis_tdata;
               dest_d     = dest_shift[39:0];
               byte_cnt_d = byte_cnt_q + BUF_AW'(1);
               if (rx_axis_tlast) begin
                  inc_bad    = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = S_IDLE;
               end else if (byte_cnt_q == BUF_AW'(5)) begin
                  drop_ovr_d = 1'b0;
                  state_d    = match ? S_BODY : S_DROP;
               end
            end
         end
         S_BODY: begin
            if (rx_axis_tvalid) begin
               // The last slot offset is written, then the frame is oversize.
               if (!ovs_q) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {nextbuf_q[NBUF_LOG2-1:0], byte_cnt_q};
                  wr_data_d = rx_axis_tdata;
                  if (cnt_max) ovs_d = 1'b1;
                  else         byte_cnt_d = byte_cnt_q + BUF_AW'(1);
               end
               if (rx_axis_tlast) begin
                  state_d    = S_IDLE;
                  byte_cnt_d = '0;
                  ovs_d      = 1'b0;
                  if (body_bad) begin
                     inc_bad = 1'b1;
                  end else begin
                     len_wr_en_d = 1'b1;
                     len_idx_d   = nextbuf_q[NBUF_LOG2-1:0];
                     len_data_d  = frame_len[BUF_AW-1:0];
                     nextbuf_d   = nextbuf_q + PW'(1);
                  end
               end
            end
         end
         S_DROP: begin
            if (rx_axis_tvalid && rx_axis_tlast) begin
               state_d    = S_IDLE;
               byte_cnt_d = '0;
               if (drop_ovr_q) inc_ovr  = 1'b1;
               else            inc_filt = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cnt_bad_d  = (inc_bad && cnt_bad_q != '1)
                 ? cnt_bad_q + 16'd1 : cnt_bad_q;
      cnt_filt_d = (inc_filt && cnt_filt_q != '1)
                 ? cnt_filt_q + 16'd1 : cnt_filt_q;
      cnt_ovr_d  = (inc_ovr && cnt_ovr_q != '1)
                 ? cnt_ovr_q + 16'd1 : cnt_ovr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= '0;
         dest_q      <= '0;
         ovs_q       <= 1'b0;
         drop_ovr_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         len_wr_en_q <= 1'b0;
         len_idx_q   <= '0;
         len_data_q  <= '0;
         nextbuf_q   <= '0;
         cnt_filt_q  <= '0;
         cnt_ovr_q   <= '0;
         cnt_bad_q   <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         dest_q      <= dest_d;
         ovs_q       <= ovs_d;
         drop_ovr_q  <= drop_ovr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         len_wr_en_q <= len_wr_en_d;
         len_idx_q   <= len_idx_d;
         len_data_q  <= len_data_d;
         nextbuf_q   <= nextbuf_d;
         cnt_filt_q  <= cnt_filt_d;
         cnt_ovr_q   <= cnt_ovr_d;
         cnt_bad_q   <= cnt_bad_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign len_wr_en    = len_wr_en_q;
   assign len_wr_idx   = len_idx_q;
   assign len_wr_data  = len_data_q;
   assign nextbuf      = nextbuf_q;
   assign full         = full_c;
   assign cnt_filtered = cnt_filt_q;
   assign cnt_overrun  = cnt_ovr_q;
   assign cnt_bad      = cnt_bad_q;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Scoreboard bench for eth_rx_frame_filter: expected slot writes and length
// commits are queued as frames are driven and matched as the DUT emits them.
module tb_eth_rx_frame_filter;

   localparam int NB = 3;
   localparam int AW = 11;
   localparam int ML = 60;

   logic        clk;
   logic        rst;
   logic [47:0] mac_address;
   logic        promiscuous;
   logic [7:0]  rx_axis_tdata;
   logic        rx_axis_tvalid;
   logic        rx_axis_tlast;
   logic        rx_axis_tuser;
   logic [NB:0] firstbuf;
   logic        wr_en;
   logic [NB+AW-1:0] wr_addr;
   logic [7:0]  wr_data;
   logic        len_wr_en;
   logic [NB-1:0] len_wr_idx;
   logic [AW-1:0] len_wr_data;
   logic [NB:0] nextbuf;
   logic        full;
   logic [15:0] cnt_filtered;
   logic [15:0] cnt_overrun;
   logic [15:0] cnt_bad;

   eth_rx_frame_filter #(.NBUF_LOG2(NB), .BUF_AW(AW), .MIN_LEN(ML)) dut (
      .clk(clk), .rst(rst),
      .mac_address(mac_address), .promiscuous(promiscuous),
      .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
      .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
      .firstbuf(firstbuf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len_wr_en(len_wr_en), .len_wr_idx(len_wr_idx),
      .len_wr_data(len_wr_data),
      .nextbuf(nextbuf), .full(full),
      .cnt_filtered(cnt_filtered), .cnt_overrun(cnt_overrun),
      .cnt_bad(cnt_bad)
   );

   typedef struct {
      logic [NB+AW-1:0] addr;
      logic [7:0]       data;
   } wr_t;

   typedef struct {
      logic [NB-1:0] idx;
      logic [AW-1:0] len;
   } len_t;

   wr_t  exp_wr[$];
   len_t exp_len[$];
   int   n_cmp;
   int   n_err;
   logic [NB:0] m_nb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard side: every DUT write / commit pops and checks one entry.
   always @(negedge clk) begin
      wr_t  ew;
      len_t el;
      if (wr_en === 1'b1) begin
         n_cmp++;
         if (exp_wr.size() == 0) begin
            n_err++;
            $display("FAIL wr_unexpected: got addr=%h data=%h, none expected",
                     wr_addr, wr_data);
         end else begin
            ew = exp_wr.pop_front();
            if (wr_addr !== ew.addr || wr_data !== ew.data) begin
               n_err++;
               $display("FAIL wr_byte: got %h/%h required %h/%h",
                        wr_addr, wr_data, ew.addr, ew.data);
            end
         end
      end
      if (len_wr_en === 1'b1) begin
         n_cmp++;
         if (exp_len.size() == 0) begin
            n_err++;
            $display("FAIL len_unexpected: got idx=%0d len=%0d",
                     len_wr_idx, len_wr_data);
         end else begin
            el = exp_len.pop_front();
            if (len_wr_idx !== el.idx || len_wr_data !== el.len) begin
               n_err++;
               $display("FAIL len_commit: got %0d/%0d required %0d/%0d",
                        len_wr_idx, len_wr_data, el.idx, el.len);
            end
         end
      end
   end

   task automatic idle(input int n);
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tuser  = 1'b0;
      rx_axis_tdata  = 8'h00;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      exp_wr.delete();
      exp_len.delete();
      m_nb = '0;
   endtask

   // Frame-level model decides the fate of the frame before it is driven.
   task automatic send_frame(input logic [47:0] dest, input int len,
                             input bit tu, input int gap);
      logic [7:0] fb[$];
      bit   full_m, match_m, commit;
      int   nwr;
      wr_t  w;
      len_t l;
      for (int i = 0; i < len; i++) begin
         if (i < 6) fb.push_back(dest[47-8*i -: 8]);
         else       fb.push_back(8'(i * 13 + len));
      end
      full_m  = (m_nb == {~firstbuf[NB], firstbuf[NB-1:0]});
      match_m = promiscuous || dest[47:24] == 24'h01005E ||
                dest == 48'hFFFF_FFFF_FFFF || dest == mac_address;
      commit  = 1'b0;
      if (full_m)        nwr = 0;
      else if (len <= 6) nwr = len;
      else if (!match_m) nwr = 6;
      else begin
         nwr    = (len < 2048) ? len : 2048;
         commit = !tu && len <= 2047 && len >= ML;
      end
      for (int i = 0; i < nwr; i++) begin
         w.addr = {m_nb[NB-1:0], 11'(i)};
         w.data = fb[i];
         exp_wr.push_back(w);
      end
      if (commit) begin
         l.idx = m_nb[NB-1:0];
         l.len = 11'(len);
         exp_len.push_back(l);
         m_nb  = m_nb + 1'b1;
      end
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         rx_axis_tvalid = 1'b1;
         rx_axis_tdata  = fb[i];
         rx_axis_tlast  = (i == len - 1);
         rx_axis_tuser  = (i == len - 1) ? tu : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      idle(gap);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      firstbuf = '0;
      idle(3);
      rst = 1'b0;
      n_cmp++;
      if (wr_en !== 1'b0 || len_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_strobes: got wr_en=%b len_wr_en=%b required 0/0",
                  wr_en, len_wr_en);
      end
      n_cmp++;
      if (nextbuf !== '0 || full !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ptr: got nextbuf=%b full=%b required 0000/0",
                  nextbuf, full);
      end
      n_cmp++;
      if (cnt_filtered !== 16'd0 || cnt_overrun !== 16'd0 ||
          cnt_bad !== 16'd0) begin
         n_err++;
         $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0",
                  cnt_filtered, cnt_overrun, cnt_bad);
      end
      n_cmp++;
      if (wr_addr !== '0 || wr_data !== 8'd0 || len_wr_idx !== '0 ||
          len_wr_data !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h/%h/%h/%h required all 0",
                  wr_addr, wr_data, len_wr_idx, len_wr_data);
      end
   endtask

   task automatic test_unicast();
      do_reset();
      send_frame(48'h2301_0089_0702, 64, 1'b0, 4);
      n_cmp++;
      if (nextbuf !== 4'd1 || exp_wr.size() != 0 || exp_len.size() != 0) begin
         n_err++;
         $display("FAIL unicast: got nextbuf=%0d pend=%0d/%0d required 1/0/0",
                  nextbuf, exp_wr.size(), exp_len.size());
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(48'hFFFF_FFFF_FFFF, 100, 1'b0, 0);
      send_frame(48'h0100_5E7F_0001, 80, 1'b0, 4);
      n_cmp++;
      if (nextbuf !== 4'd2 || exp_wr.size() != 0 || exp_len.size() != 0) begin
         n_err++;
         $display("FAIL bcast_mcast: got nextbuf=%0d pend=%0d/%0d required 2/0/0",
                  nextbuf, exp_wr.size(), exp_len.size());
      end
   endtask

   task automatic test_filter();
      do_reset();
      send_frame(48'h0200_0000_0099, 64, 1'b0, 4);
      n_cmp++;
      if (cnt_filtered !== 16'd1 || nextbuf !== 4'd0 || cnt_bad !== 16'd0) begin
         n_err++;
         $display("FAIL filter_drop: got filt=%0d nb=%0d bad=%0d required 1/0/0",
                  cnt_filtered, nextbuf, cnt_bad);
      end
      promiscuous = 1'b1;
      send_frame(48'h0200_0000_0099, 64, 1'b0, 4);
      promiscuous = 1'b0;
      n_cmp++;
      if (cnt_filtered !== 16'd1 || nextbuf !== 4'd1 ||
          exp_wr.size() != 0 || exp_len.size() != 0) begin
         n_err++;
         $display("FAIL filter_promisc: got filt=%0d nb=%0d required 1/1",
                  cnt_filtered, nextbuf);
      end
   endtask

   task automatic test_ring_full();
      do_reset();
      for (int f = 0; f < 8; f++)
         send_frame(48'h2301_0089_0702, 64, 1'b0, 1);
      idle(3);
      n_cmp++;
      if (full !== 1'b1 || nextbuf !== 4'b1000) begin
         n_err++;
         $display("FAIL ring_full: got full=%b nb=%b required 1/1000",
                  full, nextbuf);
      end
      send_frame(48'h2301_0089_0702, 64, 1'b0, 4);
      n_cmp++;
      if (cnt_overrun !== 16'd1 || nextbuf !== 4'b1000 ||
          exp_wr.size() != 0) begin
         n_err++;
         $display("FAIL ring_overrun: got ovr=%0d nb=%b required 1/1000",
                  cnt_overrun, nextbuf);
      end
      firstbuf = 4'd1;
      idle(1);
      n_cmp++;
      if (full !== 1'b0) begin
         n_err++;
         $display("FAIL ring_release: got full=%b required 0", full);
      end
      send_frame(48'h2301_0089_0702, 64, 1'b0, 4);
      n_cmp++;
      if (nextbuf !== 4'b1001 || exp_len.size() != 0 || exp_wr.size() != 0) begin
         n_err++;
         $display("FAIL ring_wrap: got nb=%b required 1001", nextbuf);
      end
      firstbuf = 4'd0;
   endtask

   task automatic test_bad_frames();
      do_reset();
      send_frame(48'h2301_0089_0702, 64, 1'b1, 2);
      n_cmp++;
      if (cnt_bad !== 16'd1 || nextbuf !== 4'd0) begin
         n_err++;
         $display("FAIL bad_tuser: got bad=%0d nb=%0d required 1/0",
                  cnt_bad, nextbuf);
      end
      send_frame(48'h2301_0089_0702, 40, 1'b0, 2);
      n_cmp++;
      if (cnt_bad !== 16'd2) begin
         n_err++;
         $display("FAIL bad_runt40: got bad=%0d required 2", cnt_bad);
      end
      send_frame(48'h2301_0089_0702, 4, 1'b0, 2);
      n_cmp++;
      if (cnt_bad !== 16'd3) begin
         n_err++;
         $display("FAIL bad_hdr_runt: got bad=%0d required 3", cnt_bad);
      end
      send_frame(48'h2301_0089_0702, 1, 1'b0, 2);
      send_frame(48'h2301_0089_0702, 59, 1'b0, 2);
      n_cmp++;
      if (cnt_bad !== 16'd5 || cnt_filtered !== 16'd0 || nextbuf !== 4'd0) begin
         n_err++;
         $display("FAIL bad_short: got bad=%0d filt=%0d nb=%0d required 5/0/0",
                  cnt_bad, cnt_filtered, nextbuf);
      end
      send_frame(48'h2301_0089_0702, 60, 1'b0, 4);
      n_cmp++;
      if (nextbuf !== 4'd1 || cnt_bad !== 16'd5 ||
          exp_wr.size() != 0 || exp_len.size() != 0) begin
         n_err++;
         $display("FAIL min_len: got nb=%0d bad=%0d required 1/5",
                  nextbuf, cnt_bad);
      end
   endtask

   task automatic test_oversize();
      do_reset();
      send_frame(48'h2301_0089_0702, 2100, 1'b0, 1);
      send_frame(48'h2301_0089_0702, 60, 1'b0, 4);
      n_cmp++;
      if (cnt_bad !== 16'd1 || nextbuf !== 4'd1 ||
          exp_wr.size() != 0 || exp_len.size() != 0) begin
         n_err++;
         $display("FAIL oversize: got bad=%0d nb=%0d pend=%0d/%0d required 1/1/0/0",
                  cnt_bad, nextbuf, exp_wr.size(), exp_len.size());
      end
      send_frame(48'h2301_0089_0702, 2047, 1'b0, 4);
      n_cmp++;
      if (cnt_bad !== 16'd1 || nextbuf !== 4'd2 || exp_len.size() != 0) begin
         n_err++;
         $display("FAIL max_len: got bad=%0d nb=%0d required 1/2",
                  cnt_bad, nextbuf);
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      m_nb           = '0;
      rst            = 1'b1;
      mac_address    = 48'h2301_0089_0702;
      promiscuous    = 1'b0;
      firstbuf       = '0;
      rx_axis_tdata  = 8'h00;
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tuser  = 1'b0;
      test_reset();
      test_unicast();
      test_back_to_back();
      test_filter();
      test_ring_full();
      test_bad_frames();
      test_oversize();
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
